branch_hazard_unit: RTL and testbench

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

---
 rtl/branch_hazard_unit.sv | 118 +++++++++++
 tb/tb_branch_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// Branch/load hazard detection for a pipeline that resolves branches in ID.
// Shadows EX/MEM/WB destination info to drive stalls, operand forwarding selects and IF flush.
module branch_hazard_unit #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [5:0]  BEQ_OP = 6'b000100,
  parameter logic [5:0]  BNE_OP = 6'b000101
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             takebranch,
  output logic [1:0]       fa,
  output logic [1:0]       fb,
  output logic             stall,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] branch_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic writes(input stage_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != 5'd0);
  endfunction

  logic is_branch;
  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;

  always_comb begin
    is_branch = id_valid && ((id_op == BEQ_OP) || (id_op == BNE_OP));
    ex_rs     = writes(ex_q,  id_rs);
    ex_rt     = writes(ex_q,  id_rt);
    mem_rs    = writes(mem_q, id_rs);
    mem_rt    = writes(mem_q, id_rt);
    wb_rs     = writes(wb_q,  id_rs);
    wb_rt     = writes(wb_q,  id_rt);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    stall = 1'b0;
    fa    = SEL_RF;
    fb    = SEL_RF;
    if (is_branch) begin
      // A branch compares in ID, so even an ALU result still in EX is too late.
      stall = ex_rs || ex_rt || (mem_q.memread && (mem_rs || mem_rt));
    end else if (id_valid) begin
      stall = ex_q.memread && (ex_rs || ex_rt);
    end

    if (is_branch && !stall) begin
      if (mem_rs && !mem_q.memread) fa = SEL_MEM;
      else if (wb_rs)               fa = SEL_WB;
      if (mem_rt && !mem_q.memread) fb = SEL_MEM;
      else if (wb_rt)               fb = SEL_WB;
    end
  end

  assign ifid_flush = takebranch && !stall;

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = id_dst;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end

    stall_count_d  = stall_count_q;
    branch_count_d = branch_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
    if (is_branch && !stall && (branch_count_q != '1))
      branch_count_d = branch_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      stall_count_q  <= '0;
      branch_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value on the same edge.
      ex_q           <= ex_d;
      mem_q          <= ex_q;
      wb_q           <= mem_q;
      stall_count_q  <= stall_count_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign branch_count = branch_count_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: branch/load-use stalls, forwarding selects,
// flush gating, saturating counters and asynchronous reset.
module tb_branch_hazard_unit;

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_ALU  = 6'b000000;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             id_valid, id_regwrite, id_memread, takebranch;
  logic [5:0]       id_op;
  logic [4:0]       id_rs, id_rt, id_dst;
  logic [1:0]       fa, fb;
  logic             stall, ifid_flush;
  logic [CNT_W-1:0] stall_count, branch_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  branch_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .takebranch   (takebranch),
    .fa           (fa),
    .fb           (fb),
    .stall        (stall),
    .ifid_flush   (ifid_flush),
    .stall_count  (stall_count),
    .branch_count (branch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic rw, input logic mr);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
    id_dst = dst; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    takebranch = 1'b1;
    nop();
    #12;
    check("rst_stall", stall, 0);
    check("rst_fa", fa, 0);
    check("rst_fb", fb, 0);
    check("rst_flush", ifid_flush, 1);
    check("rst_scnt", stall_count, 0);
    check("rst_bcnt", branch_count, 0);
    reset_n    = 1'b1;
    takebranch = 1'b0;

    // Load r5 then BEQ r5,r0: two stall cycles, then forward from WB.
    tick(); set_id(1, OP_LW, 5'd1, 5'd0, 5'd5, 1, 1);
    check("lw_nostall", stall, 0);
    tick(); set_id(1, OP_BEQ, 5'd5, 5'd0, 5'd0, 0, 0);
    check("beq_ld_st1", stall, 1);
    check("beq_ld_fa_st", fa, 0);
    tick();
    check("beq_ld_st2", stall, 1);
    tick();
    check("beq_ld_go", stall, 0);
    check("beq_ld_fa", fa, 2'b01);
    check("beq_ld_fb", fb, 2'b00);
    check("beq_ld_scnt", stall_count, 2);
    tick(); nop();
    check("beq_ld_bcnt", branch_count, 1);

    // ALU writes r3 then BEQ r3,r3: one stall, then both from MEM.
    set_id(1, OP_ALU, 5'd1, 5'd2, 5'd3, 1, 0);
    tick(); set_id(1, OP_BEQ, 5'd3, 5'd3, 5'd0, 0, 0);
    check("beq_alu_st", stall, 1);
    tick();
    check("beq_alu_go", stall, 0);
    check("beq_alu_fa", fa, 2'b10);
    check("beq_alu_fb", fb, 2'b10);
    check("beq_alu_scnt", stall_count, 3);

    // Writes to r0 never create a hazard.
    tick(); set_id(1, OP_ALU, 5'd1, 5'd1, 5'd0, 1, 0);
    tick(); set_id(1, OP_BEQ, 5'd0, 5'd0, 5'd0, 0, 0);
    check("r0_stall", stall, 0);
    check("r0_fa", fa, 0);
    check("r0_fb", fb, 0);

    // MEM and WB both write r7: MEM wins; flush passes when not stalled.
    tick(); set_id(1, OP_ALU, 5'd1, 5'd1, 5'd7, 1, 0);
    tick(); set_id(1, OP_ALU, 5'd1, 5'd1, 5'd7, 1, 0);
    tick(); nop();
    tick(); set_id(1, OP_BNE, 5'd7, 5'd2, 5'd0, 0, 0); takebranch = 1'b1; #0;
    check("prio_stall", stall, 0);
    check("prio_fa", fa, 2'b10);
    check("prio_fb", fb, 2'b00);
    check("prio_flush", ifid_flush, 1);
    takebranch = 1'b0;

    // Load r4 then ADD using r4: one load-use stall that masks takebranch.
    tick(); set_id(1, OP_LW, 5'd1, 5'd0, 5'd4, 1, 1);
    tick(); set_id(1, OP_ALU, 5'd4, 5'd1, 5'd6, 1, 0); takebranch = 1'b1; #0;
    check("lu_stall", stall, 1);
    check("lu_flush", ifid_flush, 0);
    check("lu_fa", fa, 0);
    tick();
    check("lu_go", stall, 0);
    check("lu_flush_go", ifid_flush, 1);
    check("lu_scnt", stall_count, 4);
    takebranch = 1'b0;

    // Repeated load/branch pairs: 20 more stalls drive stall_count into saturation.
    for (int i = 0; i < 10; i++) begin
      tick(); set_id(1, OP_LW, 5'd1, 5'd0, 5'd5, 1, 1);
      tick(); set_id(1, OP_BEQ, 5'd5, 5'd0, 5'd0, 0, 0);
      tick();
    end
    tick(); set_id(1, OP_LW, 5'd1, 5'd0, 5'd5, 1, 1);
    check("sat_scnt", stall_count, 4'hF);

    // Reset mid-stall drops stall and counters at once; the branch then proceeds.
    tick(); set_id(1, OP_BEQ, 5'd5, 5'd0, 5'd0, 0, 0);
    check("mid_stall", stall, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_scnt", stall_count, 0);
    check("mid_rst_bcnt", branch_count, 0);
    check("mid_rst_fa", fa, 0);
    #1 reset_n = 1'b1;
    #1;
    check("post_rst_stall", stall, 0);
    tick(); nop();
    check("post_rst_bcnt", branch_count, 1);
    check("post_rst_scnt", stall_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
